ahb_axi_bridge: RTL and testbench
=================================

# ahb_axi_bridge

AHB-Lite slave to AXI-Lite master bridge, the inverse of our AXI-to-AHB bridge. It accepts single 32-bit AHB transfers and converts each one into one AXI write (AW+W, then B) or one AXI read (AR, then R). It stretches the AHB data phase with `h_ready` low until the AXI response returns. There is one transfer in flight at a time, with no buffering beyond one address phase and one read-data register.

## Interface
- Parameters: none.
- `a_clk` in 1: clock; the AXI side advances every edge.
- `a_reset_n` in 1: reset, asynchronous, active-low.
- `h_clk_en` in 1: AHB clock enable; AHB signals are sampled, and AHB state advances, only on `a_clk` edges where it is 1.
- `h_sel` in 1: slave select.
- `h_addr` in 32: AHB address.
- `h_trans` in 2: IDLE=00, BUSY=01, NONSEQ=10, SEQ=11.
- `h_write` in 1: 1 = write.
- `h_wdata` in 32: write data, valid in the data phase.
- `h_wstrb` in 4: byte strobes, valid in the data phase.
- `h_rdata` out 32: read data.
- `h_ready` out 1: transfer done / address accepted.
- `h_resp` out 1: 0 = OKAY, 1 = ERROR.
- AXI write-address channel:
  - `aw_valid` out 1.
  - `aw_ready` in 1.
  - `aw_addr` out 32.
- AXI write-data channel:
  - `w_valid` out 1.
  - `w_ready` in 1.
  - `w_data` out 32.
  - `w_strb` out 4.
- AXI write-response channel:
  - `b_valid` in 1.
  - `b_ready` out 1.
  - `b_resp` in 2.
- AXI read-address channel:
  - `ar_valid` out 1.
  - `ar_ready` in 1.
  - `ar_addr` out 32.
- AXI read-data channel:
  - `r_valid` in 1.
  - `r_ready` out 1.
  - `r_data` in 32.
  - `r_resp` in 2.

## Operation
- Accept condition: `h_clk_en & h_ready & h_sel & h_trans[1]`.
  - On accept, register `h_addr` and `h_write`, then go to `W_REQ` or `R_REQ`.
  - IDLE and BUSY transfers, or `h_sel`=0, get a zero-wait OKAY; the bridge stays in `IDLE`.
- States:
  - `IDLE`: `h_ready`=1, `h_resp`=0.
  - `W_REQ`:
    - `aw_valid` is held until the AW handshake; `aw_addr` = registered address.
    - `w_valid` is held until the W handshake; `w_data`/`w_strb` = live `h_wdata`/`h_wstrb`.
    - Each channel has a done flag; the two handshakes may occur in either order or together.
    - When both are done (including same cycle), go to `W_RESP`.
  - `W_RESP`: `b_ready`=1. On `b_valid`, go to `DONE` if `b_resp[1]`=0, else `ERR1`.
  - `R_REQ`: `ar_valid`=1, `ar_addr` = registered address. On `ar_ready`, go to `R_RESP`.
  - `R_RESP`: `r_ready`=1. On `r_valid`, load `h_rdata` <= `r_data` (loaded for both OKAY and error responses), then go to `DONE` if `r_resp[1]`=0, else `ERR1`.
  - `DONE`: `h_ready`=1, `h_resp`=0. Held until a `h_clk_en` edge. On that edge, apply the accept condition (pipelined next address): go to `W_REQ`/`R_REQ` if accepted, else `IDLE`.
  - `ERR1`: `h_ready`=0, `h_resp`=1. On a `h_clk_en` edge, go to `ERR2`.
  - `ERR2`: `h_ready`=1, `h_resp`=1. On a `h_clk_en` edge, same exit rule as `DONE`.
- Response mapping: OKAY (00) and EXOKAY (01) map to OKAY; SLVERR (10) and DECERR (11) map to ERROR.
- `h_rdata` holds its value until the next read completes.
- Valid discipline:
  - AXI valids never drop before their handshake.
  - At most one AXI transaction is outstanding.
  - `aw_valid`, `w_valid` and `ar_valid` are never asserted together.
  - `b_ready` and `r_ready` are 0 outside `W_RESP` and `R_RESP`.

## Timing
- Reset values:
  - State = `IDLE`, `h_ready`=1, `h_resp`=0, `h_rdata`=0.
  - All AXI valids and readies = 0.
  - Done flags = 0.
  - Address and write registers = 0.
- Reset mid-transfer: all outputs return to reset values immediately (asynchronous) and the outstanding AXI transaction is abandoned.
- `h_ready` and `h_resp` are decoded from state registers only, with no combinational path from AXI inputs.
- Write with `h_clk_en`=1 and AXI always ready:
  - Cycle 0: accept edge.
  - Cycle 1: `W_REQ` (AW and W handshake).
  - Cycle 2: `W_RESP` (B handshake).
  - Cycle 3: `DONE`.
  - Result: 2 wait states (`h_ready` low in cycles 1–2).
- Read has the same latency; `h_rdata` is valid in cycle 3.
- Each cycle of AXI stall adds one wait state.
- `DONE`, `ERR1` and `ERR2` each last until the next `h_clk_en` edge, so each spans at least one AHB cycle.
- `h_wdata` is sampled live during `W_REQ`; the AHB master holds it stable for the whole data phase.

## Test plan
- Write 0x1000 with `h_wdata`=0xDEADBEEF, `h_wstrb`=0xF, all AXI ready, `h_clk_en`=1 -> `aw_addr`=0x1000 and `w_data`=0xDEADBEEF in cycle 1; `b_ready` in cycle 2; `h_ready`=1 with `h_resp`=0 in cycle 3.
- Read 0x2004 with `ar_ready` delayed 3 cycles and `r_data`=0x12345678 -> `ar_valid` held 4 cycles; 5 wait states; `h_rdata`=0x12345678, OKAY.
- Write with `w_ready` 2 cycles before `aw_ready` -> `w_valid` drops after its handshake, `aw_valid` stays until its own; exactly one B wait follows.
- Read with `r_resp`=10 -> one cycle of `h_ready`=0/`h_resp`=1, then one cycle of `h_ready`=1/`h_resp`=1; a NONSEQ write presented in `ERR2` is accepted on that edge.
- Back-to-back read then write, plus an interleaved BUSY, with `h_clk_en` toggling every other cycle -> BUSY gets a zero-wait OKAY; each transfer is accepted only on enabled edges; `DONE` persists until an enabled edge.
- Assert `a_reset_n`=0 during `R_RESP` -> `ar_valid`/`r_ready` = 0 and `h_ready`=1 immediately; after release, a new read completes normally.

Source files
------------

// File: rtl/ahb_axi_bridge.sv
// AHB-Lite slave to AXI-Lite master bridge.
// Each AHB transfer is turned into exactly one AXI write or read, and the AHB
// data phase is stretched (h_ready low) until the AXI response comes back.
// Only one AXI transaction is ever outstanding.
module ahb_axi_bridge (
    input  logic        a_clk,
    input  logic        a_reset_n,
    input  logic        h_clk_en,
    input  logic        h_sel,
    input  logic [31:0] h_addr,
    input  logic [1:0]  h_trans,
    input  logic        h_write,
    input  logic [31:0] h_wdata,
    input  logic [3:0]  h_wstrb,
    output logic [31:0] h_rdata,
    output logic        h_ready,
    output logic        h_resp,
    output logic        aw_valid,
    input  logic        aw_ready,
    output logic [31:0] aw_addr,
    output logic        w_valid,
    input  logic        w_ready,
    output logic [31:0] w_data,
    output logic [3:0]  w_strb,
    input  logic        b_valid,
    output logic        b_ready,
    input  logic [1:0]  b_resp,
    output logic        ar_valid,
    input  logic        ar_ready,
    output logic [31:0] ar_addr,
    input  logic        r_valid,
    output logic        r_ready,
    input  logic [31:0] r_data,
    input  logic [1:0]  r_resp
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_W_REQ,
        S_W_RESP,
        S_R_REQ,
        S_R_RESP,
        S_DONE,
        S_ERR1,
        S_ERR2
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [31:0] r_addr;
    logic        r_write;
    logic        r_aw_done;
    logic        r_w_done;
    logic [31:0] r_rdata;

    logic        w_accept;
    logic        w_aw_hs;
    logic        w_w_hs;
    logic        w_aw_fin;
    logic        w_w_fin;
    state_t      w_issue;
    logic        w_unused;

    // A new transfer is only taken on an enabled AHB edge while h_ready is high
    // (IDLE, DONE, ERR2), which gives the pipelined next-address behaviour.
    assign w_accept = h_clk_en & h_ready & h_sel & h_trans[1];
    assign w_issue  = h_write ? S_W_REQ : S_R_REQ;

    // AW and W complete independently; a channel counts as finished either
    // from an earlier handshake or from one happening this cycle.
    assign w_aw_hs  = aw_valid & aw_ready;
    assign w_w_hs   = w_valid & w_ready;
    assign w_aw_fin = r_aw_done | w_aw_hs;
    assign w_w_fin  = r_w_done | w_w_hs;

    // Address and data come straight from registers / the live AHB data phase.
    assign aw_addr  = r_addr;
    assign ar_addr  = r_addr;
    assign w_data   = h_wdata;
    assign w_strb   = h_wstrb;
    assign h_rdata  = r_rdata;

    // Low response bits (OKAY vs EXOKAY, SLVERR vs DECERR) do not change the
    // AHB result; the registered direction is kept for debug visibility.
    assign w_unused = ^{h_trans[0], b_resp[0], r_resp[0], r_write};

    // State register.
    always_ff @(posedge a_clk or negedge a_reset_n) begin
        if (!a_reset_n) r_state <= S_IDLE;
        else            r_state <= w_next;
    end

    // Next state and state-decoded outputs (no AXI input reaches h_ready/h_resp).
    always_comb begin
        w_next   = r_state;
        h_ready  = 1'b0;
        h_resp   = 1'b0;
        aw_valid = 1'b0;
        w_valid  = 1'b0;
        b_ready  = 1'b0;
        ar_valid = 1'b0;
        r_ready  = 1'b0;
        case (r_state)
            S_IDLE: begin
                h_ready = 1'b1;
                if (w_accept) w_next = w_issue;
            end
            S_W_REQ: begin
                aw_valid = ~r_aw_done;
                w_valid  = ~r_w_done;
                if (w_aw_fin && w_w_fin) w_next = S_W_RESP;
            end
            S_W_RESP: begin
                b_ready = 1'b1;
                if (b_valid) w_next = b_resp[1] ? S_ERR1 : S_DONE;
            end
            S_R_REQ: begin
                ar_valid = 1'b1;
                if (ar_ready) w_next = S_R_RESP;
            end
            S_R_RESP: begin
                r_ready = 1'b1;
                if (r_valid) w_next = r_resp[1] ? S_ERR1 : S_DONE;
            end
            S_DONE: begin
                h_ready = 1'b1;
                if (h_clk_en) w_next = w_accept ? w_issue : S_IDLE;
            end
            S_ERR1: begin
                h_resp = 1'b1;
                if (h_clk_en) w_next = S_ERR2;
            end
            S_ERR2: begin
                h_ready = 1'b1;
                h_resp  = 1'b1;
                if (h_clk_en) w_next = w_accept ? w_issue : S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Capture the AHB address phase on accept.
    always_ff @(posedge a_clk or negedge a_reset_n) begin
        if (!a_reset_n) begin
            r_addr  <= 32'h0;
            r_write <= 1'b0;
        end else if (w_accept) begin
            r_addr  <= h_addr;
            r_write <= h_write;
        end
    end

    // Per-channel done flags; cleared whenever the write request phase ends.
    always_ff @(posedge a_clk or negedge a_reset_n) begin
        if (!a_reset_n) begin
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
        end else if (r_state == S_W_REQ && !(w_aw_fin && w_w_fin)) begin
            r_aw_done <= w_aw_fin;
            r_w_done  <= w_w_fin;
        end else begin
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
        end
    end

    // Read data register, loaded on every read response (error data included).
    always_ff @(posedge a_clk or negedge a_reset_n) begin
        if (!a_reset_n)                      r_rdata <= 32'h0;
        else if (r_state == S_R_RESP && r_valid) r_rdata <= r_data;
    end

endmodule

// File: tb/tb_ahb_axi_bridge.sv
// Directed bench for ahb_axi_bridge: expected values are hand-derived cycle by
// cycle; inputs change 1 time unit after a rising edge and outputs are checked
// in the same window.
module tb_ahb_axi_bridge;

    logic        a_clk;
    logic        a_reset_n;
    logic        h_clk_en;
    logic        h_sel;
    logic [31:0] h_addr;
    logic [1:0]  h_trans;
    logic        h_write;
    logic [31:0] h_wdata;
    logic [3:0]  h_wstrb;
    logic [31:0] h_rdata;
    logic        h_ready;
    logic        h_resp;
    logic        aw_valid;
    logic        aw_ready;
    logic [31:0] aw_addr;
    logic        w_valid;
    logic        w_ready;
    logic [31:0] w_data;
    logic [3:0]  w_strb;
    logic        b_valid;
    logic        b_ready;
    logic [1:0]  b_resp;
    logic        ar_valid;
    logic        ar_ready;
    logic [31:0] ar_addr;
    logic        r_valid;
    logic        r_ready;
    logic [31:0] r_data;
    logic [1:0]  r_resp;

    int total = 0;
    int bad   = 0;

    localparam logic [1:0] T_IDLE   = 2'b00;
    localparam logic [1:0] T_BUSY   = 2'b01;
    localparam logic [1:0] T_NONSEQ = 2'b10;

    ahb_axi_bridge dut (
        .a_clk(a_clk), .a_reset_n(a_reset_n), .h_clk_en(h_clk_en),
        .h_sel(h_sel), .h_addr(h_addr), .h_trans(h_trans), .h_write(h_write),
        .h_wdata(h_wdata), .h_wstrb(h_wstrb), .h_rdata(h_rdata),
        .h_ready(h_ready), .h_resp(h_resp),
        .aw_valid(aw_valid), .aw_ready(aw_ready), .aw_addr(aw_addr),
        .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data), .w_strb(w_strb),
        .b_valid(b_valid), .b_ready(b_ready), .b_resp(b_resp),
        .ar_valid(ar_valid), .ar_ready(ar_ready), .ar_addr(ar_addr),
        .r_valid(r_valid), .r_ready(r_ready), .r_data(r_data), .r_resp(r_resp)
    );

    initial a_clk = 1'b0;
    always #5 a_clk = ~a_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge a_clk);
        #1;
    endtask

    task automatic ahb(input logic sel, input logic [1:0] trans, input logic wr, input logic [31:0] addr);
        h_sel   = sel;
        h_trans = trans;
        h_write = wr;
        h_addr  = addr;
    endtask

    task automatic axi(input logic awr, input logic wr, input logic bv, input logic arr, input logic rv);
        aw_ready = awr;
        w_ready  = wr;
        b_valid  = bv;
        ar_ready = arr;
        r_valid  = rv;
    endtask

    initial begin
        a_reset_n = 1'b0;
        h_clk_en  = 1'b1;
        ahb(1'b0, T_IDLE, 1'b0, 32'h0);
        h_wdata = 32'h0;
        h_wstrb = 4'h0;
        axi(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        b_resp = 2'b00;
        r_data = 32'h0;
        r_resp = 2'b00;

        // ---- reset state
        #1;
        chk("rst_h_ready", h_ready, 1);
        chk("rst_h_resp", h_resp, 0);
        chk("rst_h_rdata", h_rdata, 0);
        chk("rst_valids", {aw_valid, w_valid, ar_valid}, 0);
        chk("rst_readies", {b_ready, r_ready}, 0);
        chk("rst_addr", aw_addr, 0);
        step();
        a_reset_n = 1'b1;
        step();

        // ---- write 0x1000, everything ready
        ahb(1'b1, T_NONSEQ, 1'b1, 32'h1000);
        axi(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        b_resp = 2'b00;
        step();                                   // cycle 1: W_REQ
        ahb(1'b1, T_IDLE, 1'b0, 32'h0);
        h_wdata = 32'hDEADBEEF;
        h_wstrb = 4'hF;
        #1;
        chk("w1_aw_valid", aw_valid, 1);
        chk("w1_aw_addr", aw_addr, 32'h1000);
        chk("w1_w_valid", w_valid, 1);
        chk("w1_w_data", w_data, 32'hDEADBEEF);
        chk("w1_w_strb", w_strb, 4'hF);
        chk("w1_h_ready_c1", h_ready, 0);
        chk("w1_no_ar", ar_valid, 0);
        step();                                   // cycle 2: W_RESP
        chk("w1_b_ready", b_ready, 1);
        chk("w1_valids_c2", {aw_valid, w_valid}, 0);
        chk("w1_h_ready_c2", h_ready, 0);
        step();                                   // cycle 3: DONE
        chk("w1_h_ready_c3", h_ready, 1);
        chk("w1_h_resp_c3", h_resp, 0);
        chk("w1_b_ready_c3", b_ready, 0);
        axi(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step();                                   // back to IDLE

        // ---- read 0x2004, ar_ready held off 3 cycles, EXOKAY response
        ahb(1'b1, T_NONSEQ, 1'b0, 32'h2004);
        axi(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        r_data = 32'h12345678;
        r_resp = 2'b01;
        step();                                   // cycle 1
        ahb(1'b1, T_IDLE, 1'b0, 32'h0);
        chk("r1_ar_valid_c1", ar_valid, 1);
        chk("r1_ar_addr", ar_addr, 32'h2004);
        chk("r1_h_ready_c1", h_ready, 0);
        chk("r1_no_aw", {aw_valid, w_valid}, 0);
        step();                                   // cycle 2
        chk("r1_ar_valid_c2", ar_valid, 1);
        chk("r1_h_ready_c2", h_ready, 0);
        step();                                   // cycle 3
        chk("r1_ar_valid_c3", ar_valid, 1);
        chk("r1_h_ready_c3", h_ready, 0);
        chk("r1_r_ready_c3", r_ready, 0);
        step();                                   // cycle 4
        ar_ready = 1'b1;
        chk("r1_ar_valid_c4", ar_valid, 1);
        chk("r1_h_ready_c4", h_ready, 0);
        step();                                   // cycle 5: R_RESP
        ar_ready = 1'b0;
        chk("r1_ar_valid_c5", ar_valid, 0);
        chk("r1_r_ready_c5", r_ready, 1);
        chk("r1_h_ready_c5", h_ready, 0);
        step();                                   // cycle 6: DONE
        chk("r1_h_ready_c6", h_ready, 1);
        chk("r1_h_resp_c6", h_resp, 0);
        chk("r1_h_rdata", h_rdata, 32'h12345678);
        chk("r1_r_ready_c6", r_ready, 0);

        // ---- write 0x3000 presented in DONE; W handshakes 2 cycles before AW
        ahb(1'b1, T_NONSEQ, 1'b1, 32'h3000);
        axi(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        step();                                   // cycle 1: W_REQ, W handshake
        ahb(1'b1, T_IDLE, 1'b0, 32'h0);
        h_wdata = 32'hA5A50001;
        h_wstrb = 4'h3;
        #1;
        chk("w2_valids_c1", {aw_valid, w_valid}, 2'b11);
        chk("w2_aw_addr", aw_addr, 32'h3000);
        chk("w2_w_data", w_data, 32'hA5A50001);
        chk("w2_w_strb", w_strb, 4'h3);
        step();                                   // cycle 2
        chk("w2_valids_c2", {aw_valid, w_valid}, 2'b10);
        chk("w2_h_ready_c2", h_ready, 0);
        step();                                   // cycle 3: AW handshake
        aw_ready = 1'b1;
        chk("w2_valids_c3", {aw_valid, w_valid}, 2'b10);
        chk("w2_b_ready_c3", b_ready, 0);
        step();                                   // cycle 4: W_RESP
        aw_ready = 1'b0;
        b_valid  = 1'b1;
        chk("w2_valids_c4", {aw_valid, w_valid}, 2'b00);
        chk("w2_b_ready_c4", b_ready, 1);
        chk("w2_h_ready_c4", h_ready, 0);
        step();                                   // cycle 5: DONE
        chk("w2_h_ready_c5", h_ready, 1);
        chk("w2_b_ready_c5", b_ready, 0);

        // ---- read 0x4000 with SLVERR, presented in DONE
        ahb(1'b1, T_NONSEQ, 1'b0, 32'h4000);
        axi(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        r_data = 32'hBAD0BAD0;
        r_resp = 2'b10;
        step();                                   // R_REQ
        ahb(1'b1, T_IDLE, 1'b0, 32'h0);
        chk("r2_ar_valid", ar_valid, 1);
        chk("r2_ar_addr", ar_addr, 32'h4000);
        chk("r2_aw_valid", aw_valid, 0);
        step();                                   // R_RESP
        chk("r2_r_ready", r_ready, 1);
        step();                                   // ERR1
        chk("r2_err1", {h_ready, h_resp}, 2'b01);
        chk("r2_h_rdata", h_rdata, 32'hBAD0BAD0);
        ahb(1'b1, T_NONSEQ, 1'b1, 32'h5000);     // becomes visible in ERR2
        axi(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        b_resp = 2'b00;
        step();                                   // ERR2
        chk("r2_err2", {h_ready, h_resp}, 2'b11);
        step();                                   // W_REQ for 0x5000
        ahb(1'b1, T_IDLE, 1'b0, 32'h0);
        h_wdata = 32'h0BADF00D;
        h_wstrb = 4'hF;
        #1;
        chk("w3_aw_valid", aw_valid, 1);
        chk("w3_aw_addr", aw_addr, 32'h5000);
        chk("w3_w_data", w_data, 32'h0BADF00D);
        chk("w3_hresp", {h_ready, h_resp}, 2'b00);
        step();                                   // W_RESP
        chk("w3_b_ready", b_ready, 1);
        step();                                   // DONE
        chk("w3_done", {h_ready, h_resp}, 2'b10);
        chk("w3_rdata_kept", h_rdata, 32'hBAD0BAD0);

        // ---- h_clk_en toggling: read, BUSY, write
        h_clk_en = 1'b0;
        ahb(1'b1, T_NONSEQ, 1'b0, 32'h6000);
        axi(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        r_data = 32'h600D600D;
        r_resp = 2'b00;
        step();                                   // disabled edge: still DONE
        chk("e_rd_not_taken", ar_valid, 0);
        chk("e_done_held", {h_ready, h_resp}, 2'b10);
        h_clk_en = 1'b1;
        step();                                   // enabled edge: R_REQ
        chk("e_rd_taken", ar_valid, 1);
        chk("e_rd_addr", ar_addr, 32'h6000);
        h_clk_en = 1'b0;
        ahb(1'b1, T_BUSY, 1'b0, 32'h6004);
        step();                                   // AXI side runs: R_RESP
        chk("e_r_ready", r_ready, 1);
        h_clk_en = 1'b1;
        step();                                   // DONE
        chk("e_rd_done", {h_ready, h_resp}, 2'b10);
        chk("e_rdata", h_rdata, 32'h600D600D);
        h_clk_en = 1'b0;
        step();                                   // disabled: DONE persists
        chk("e_done_persist", h_ready, 1);
        h_clk_en = 1'b1;
        step();                                   // BUSY on enabled edge -> IDLE
        chk("e_busy_zero_wait", {h_ready, h_resp}, 2'b10);
        chk("e_busy_no_axi", {aw_valid, w_valid, ar_valid}, 0);
        h_clk_en = 1'b0;
        ahb(1'b1, T_NONSEQ, 1'b1, 32'h7000);
        axi(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        step();                                   // disabled: still IDLE
        chk("e_wr_not_taken", aw_valid, 0);
        chk("e_wr_idle_ready", h_ready, 1);
        h_clk_en = 1'b1;
        step();                                   // W_REQ
        h_clk_en = 1'b0;
        ahb(1'b1, T_IDLE, 1'b0, 32'h0);
        h_wdata = 32'h77770007;
        h_wstrb = 4'hC;
        #1;
        chk("e_wr_taken", {aw_valid, w_valid}, 2'b11);
        chk("e_wr_addr", aw_addr, 32'h7000);
        chk("e_wr_data", w_data, 32'h77770007);
        step();                                   // W_RESP
        chk("e_wr_b_ready", b_ready, 1);
        h_clk_en = 1'b1;
        step();                                   // DONE
        chk("e_wr_done", {h_ready, h_resp}, 2'b10);
        axi(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step();                                   // IDLE

        // ---- asynchronous reset during R_RESP, then a clean read
        ahb(1'b1, T_NONSEQ, 1'b0, 32'h8000);
        axi(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        step();                                   // R_REQ
        ahb(1'b1, T_IDLE, 1'b0, 32'h0);
        step();                                   // R_RESP, no r_valid
        chk("x_r_ready", r_ready, 1);
        chk("x_h_ready_before", h_ready, 0);
        #2;
        a_reset_n = 1'b0;
        #1;
        chk("x_r_ready_rst", r_ready, 0);
        chk("x_ar_valid_rst", ar_valid, 0);
        chk("x_h_ready_rst", h_ready, 1);
        chk("x_h_rdata_rst", h_rdata, 0);
        chk("x_addr_rst", ar_addr, 0);
        step();
        a_reset_n = 1'b1;
        ahb(1'b1, T_NONSEQ, 1'b0, 32'h9000);
        axi(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        r_data = 32'h0F0F0F0F;
        r_resp = 2'b00;
        step();                                   // R_REQ
        ahb(1'b1, T_IDLE, 1'b0, 32'h0);
        chk("x_ar_valid", ar_valid, 1);
        chk("x_ar_addr", ar_addr, 32'h9000);
        step();                                   // R_RESP
        chk("x_r_ready2", r_ready, 1);
        step();                                   // DONE
        chk("x_done", {h_ready, h_resp}, 2'b10);
        chk("x_rdata", h_rdata, 32'h0F0F0F0F);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
